frame_reader: RTL and testbench
===============================

FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter WIDTH, default 8, width of one height or coordinate field.
REQ-002 Parameter MEM_WIDTH, default 10, playfield columns.
REQ-003 Parameter MEM_HEIGHT, default 20, playfield rows.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 write_mem  input  1  one-cycle strobe; the new_* buses are valid.
REQ-007 new_border  input  MEM_WIDTH*WIDTH  column heights; column x at bits [x*WIDTH +: WIDTH].
REQ-008 new_rho_x  input  4*WIDTH  x coordinates of the 4 figure cells; cell k at bits [k*WIDTH +: WIDTH].
REQ-009 new_rho_y  input  4*WIDTH  y coordinates of the 4 figure cells, same packing.
REQ-010 row_data  output  MEM_WIDTH  occupancy of the current row; bit x is column x.
REQ-011 row_idx  output  WIDTH  index of the current row; 0 is the bottom row.
REQ-012 row_valid  output  1  row_data/row_idx valid.
REQ-013 row_ready  input  1  sink accepts the row; a transfer occurs when row_valid && row_ready.
REQ-014 frame_last  output  1  high with row_valid when row_idx == 0.
REQ-015 busy  output  1  high in SCAN or while a pending snapshot is held.

Function
REQ-016 Block SHALL be the read side of the playfield store: each write_mem captures a snapshot of new_border, new_rho_x and new_rho_y, and the block streams it out as MEM_HEIGHT rows.
REQ-017 Cell (x,y) SHALL be 1 if y < border[x] (unsigned compare) or, with figure overlay enabled (REQ-032), if any k in 0..3 has rho_x[k]==x and rho_y[k]==y; figure coordinates outside the playfield SHALL be ignored.
REQ-018 FSM states: IDLE, SCAN.
REQ-019 IDLE + write_mem: capture the snapshot into the active register, set row_idx = MEM_HEIGHT-1, go to SCAN; row_valid SHALL be high in the next cycle (latency 1).
REQ-020 SCAN: row_valid=1; rows SHALL be emitted top to bottom, from MEM_HEIGHT-1 down to 0.
REQ-021 While row_valid && !row_ready, row_data, row_idx and frame_last SHALL hold stable.
REQ-022 On a transfer with row_idx>0, row_idx SHALL decrement by 1 and the next row SHALL appear in the following cycle with no bubble.
REQ-023 On a transfer with row_idx==0, the next state SHALL be SCAN of the pending snapshot if one exists, otherwise IDLE with row_valid=0 in the next cycle.
REQ-024 write_mem in SCAN SHALL store the snapshot in a one-deep pending register; the current frame SHALL NOT be altered.
REQ-025 A further write_mem while pending is full SHALL overwrite it (newest wins); there is no overflow error.
REQ-026 write_mem in the same cycle as the final transfer SHALL start the next frame from the write_mem data, and this data SHALL supersede any older pending snapshot.
REQ-027 row_valid SHALL NOT be asserted in IDLE; row_ready SHALL be ignored in IDLE.

Reset
REQ-028 rst high SHALL immediately force IDLE and clear the active and pending snapshots.
REQ-029 Reset values: row_valid=0, row_data=0, row_idx=0, frame_last=0, busy=0.
REQ-030 Reset during SCAN SHALL abort the frame; no further rows SHALL be emitted until a new write_mem after rst is released.
REQ-031 A write_mem in a cycle with rst high SHALL be discarded.

Configuration
REQ-032 Macro FRAME_READER_FIGURE_EN: when defined, the figure cells SHALL be ORed into row_data per REQ-017; when undefined, new_rho_x and new_rho_y SHALL be unused, only border heights SHALL set row_data, and all timing SHALL be identical.

Verification
REQ-033 Borders all 3, figure at (4,5),(5,5),(4,6),(5,6), one write_mem, row_ready=1 -> 20 rows from idx 19 to 0 in consecutive cycles; idx 6 and 5 = 0x030 (0x000 without macro); idx 2..0 = 0x3FF; frame_last only at idx 0.
REQ-034 Same frame with row_ready toggling 1/0 each cycle -> row_data and row_idx stable across stalls; exactly 20 transfers; row_valid low after the last transfer.
REQ-035 Frame A active, write_mem B at row 15, then write_mem C at row 10 -> A completes intact, C follows with no idle cycle, B is never emitted.
REQ-036 write_mem D in the same cycle as the final transfer of frame A -> next cycle row_valid=1, row_idx=19, D contents.
REQ-037 rst pulsed at row 12 -> row_valid=0 and busy=0 immediately, no rows until next write_mem; next frame starts at idx 19.
REQ-038 Border column 0 = 255, figure cell at x=12 -> column 0 set in all rows; out-of-range figure cell not shown; no X on outputs.

Source files
------------

// File: rtl/frame_reader.sv
// Streams a captured playfield snapshot as MEM_HEIGHT rows, top row first, one cycle after write_mem.
// Rows hold under !row_ready; one pending snapshot (newest wins). `FRAME_READER_FIGURE_EN overlays the figure.
module frame_reader #(
  parameter int WIDTH      = 8,
  parameter int MEM_WIDTH  = 10,
  parameter int MEM_HEIGHT = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_mem,
  input  logic [MEM_WIDTH*WIDTH-1:0] new_border,
  input  logic [4*WIDTH-1:0]         new_rho_x,
  input  logic [4*WIDTH-1:0]         new_rho_y,
  output logic [MEM_WIDTH-1:0]       row_data,
  output logic [WIDTH-1:0]           row_idx,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic                       frame_last,
  output logic                       busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MEM_HEIGHT - 1);

  function automatic logic [MEM_WIDTH-1:0] f_border(input logic [MEM_WIDTH*WIDTH-1:0] b,
                                                    input logic [WIDTH-1:0] y);
    logic [MEM_WIDTH-1:0] r;
    r = '0;
    for (int x = 0; x < MEM_WIDTH; x++)
      r[x] = (y < b[x*WIDTH +: WIDTH]);
    return r;
  endfunction

  state_t                     r_state;
  logic [MEM_WIDTH*WIDTH-1:0] r_act_border;
  logic [MEM_WIDTH*WIDTH-1:0] r_pend_border;
  logic                       r_pend_vld;
  logic [MEM_WIDTH-1:0]       r_row_data;
  logic [WIDTH-1:0]           r_row_idx;
  logic                       r_row_valid;
  logic                       r_frame_last;

  logic                       w_xfer;
  logic                       w_last;
  logic                       w_start;
  logic [WIDTH-1:0]           w_next_idx;
  logic [MEM_WIDTH*WIDTH-1:0] w_src_border;
  logic [MEM_WIDTH*WIDTH-1:0] w_use_border;
  logic [MEM_WIDTH-1:0]       w_next_row;

  assign w_xfer  = r_row_valid & row_ready;
  assign w_last  = w_xfer & (r_row_idx == '0);
  // A write_mem coinciding with the final transfer beats the older pending snapshot.
  assign w_start = ((r_state == IDLE) & write_mem) | (w_last & (write_mem | r_pend_vld));

  assign w_src_border = write_mem ? new_border : r_pend_border;
  assign w_use_border = w_start ? w_src_border : r_act_border;
  assign w_next_idx   = w_start ? TOP : (r_row_idx - WIDTH'(1));

`ifdef FRAME_READER_FIGURE_EN
  function automatic logic [MEM_WIDTH-1:0] f_fig(input logic [4*WIDTH-1:0] rx,
                                                 input logic [4*WIDTH-1:0] ry,
                                                 input logic [WIDTH-1:0] y);
    logic [MEM_WIDTH-1:0] r;
    r = '0;
    for (int x = 0; x < MEM_WIDTH; x++)
      for (int k = 0; k < 4; k++)
        if ((rx[k*WIDTH +: WIDTH] == WIDTH'(x)) && (ry[k*WIDTH +: WIDTH] == y))
          r[x] = 1'b1;
    return r;
  endfunction

  logic [4*WIDTH-1:0] r_act_rx, r_act_ry, r_pend_rx, r_pend_ry;
  logic [4*WIDTH-1:0] w_use_rx, w_use_ry;

  assign w_use_rx   = w_start ? (write_mem ? new_rho_x : r_pend_rx) : r_act_rx;
  assign w_use_ry   = w_start ? (write_mem ? new_rho_y : r_pend_ry) : r_act_ry;
  assign w_next_row = f_border(w_use_border, w_next_idx) | f_fig(w_use_rx, w_use_ry, w_next_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_rx  <= '0;
      r_act_ry  <= '0;
      r_pend_rx <= '0;
      r_pend_ry <= '0;
    end else if (w_start) begin
      r_act_rx <= w_use_rx;
      r_act_ry <= w_use_ry;
    end else if ((r_state == SCAN) && write_mem) begin
      r_pend_rx <= new_rho_x;
      r_pend_ry <= new_rho_y;
    end
  end
`else
  logic w_unused_rho;
  assign w_unused_rho = ^{new_rho_x, new_rho_y};
  assign w_next_row   = f_border(w_use_border, w_next_idx);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_act_border  <= '0;
      r_pend_border <= '0;
      r_pend_vld    <= 1'b0;
      r_row_data    <= '0;
      r_row_idx     <= '0;
      r_row_valid   <= 1'b0;
      r_frame_last  <= 1'b0;
    end else begin
      if (w_start) begin
        r_state      <= SCAN;
        r_act_border <= w_use_border;
        r_row_idx    <= TOP;
        r_row_data   <= w_next_row;
        r_row_valid  <= 1'b1;
        r_frame_last <= (TOP == '0);
      end else if (w_last) begin
        r_state      <= IDLE;
        r_row_data   <= '0;
        r_row_valid  <= 1'b0;
        r_frame_last <= 1'b0;
      end else if (w_xfer) begin
        r_row_idx    <= w_next_idx;
        r_row_data   <= w_next_row;
        r_frame_last <= (r_row_idx == WIDTH'(1));
      end

      if (w_start) begin
        r_pend_vld <= 1'b0;
      end else if ((r_state == SCAN) && write_mem) begin
        r_pend_border <= new_border;
        r_pend_vld    <= 1'b1;
      end
    end
  end

  assign row_data   = r_row_data;
  assign row_idx    = r_row_idx;
  assign row_valid  = r_row_valid;
  assign frame_last = r_frame_last;
  assign busy       = (r_state == SCAN) | r_pend_vld;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: vector table for a full frame plus hand sequences for stalls, pending, reset.
module tb_frame_reader;

  logic        clk, rst, write_mem, row_ready;
  logic [79:0] new_border;
  logic [31:0] new_rho_x, new_rho_y;
  logic [9:0]  row_data;
  logic [7:0]  row_idx;
  logic        row_valid, frame_last, busy;

  int checks = 0;
  int failures = 0;

`ifdef FRAME_READER_FIGURE_EN
  localparam logic [9:0] FIG = 10'h030;
`else
  localparam logic [9:0] FIG = 10'h000;
`endif

  frame_reader dut (
    .clk(clk), .rst(rst), .write_mem(write_mem),
    .new_border(new_border), .new_rho_x(new_rho_x), .new_rho_y(new_rho_y),
    .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
    .row_ready(row_ready), .frame_last(frame_last), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       rdy;
    logic       vld;
    logic [7:0] idx;
    logic [9:0] dat;
    logic       last;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [79:0] b, input logic [31:0] rx, input logic [31:0] ry);
    new_border = b;
    new_rho_x  = rx;
    new_rho_y  = ry;
    write_mem  = 1'b1;
  endtask

  task automatic chk_row(input string nm, input int idx, input logic [9:0] dat);
    chk({nm, ".valid"}, 32'(row_valid), 32'(1'b1));
    chk({nm, ".idx"}, 32'(row_idx), 32'(idx));
    chk({nm, ".data"}, 32'(row_data), 32'(dat));
    chk({nm, ".last"}, 32'(frame_last), 32'(idx == 0));
    chk({nm, ".noX"}, 32'($isunknown({row_data, row_idx, row_valid, frame_last, busy})), 32'(0));
  endtask

  // Rows idx < cut carry lo, the rest hi; ends one cycle after the idx-0 transfer.
  task automatic drain(input string nm, input int start, input int cut,
                       input logic [9:0] lo, input logic [9:0] hi);
    row_ready = 1'b1;
    for (int i = start; i >= 0; i--) begin
      chk_row(nm, i, (i < cut) ? lo : hi);
      step();
    end
    chk({nm, ".end_valid"}, 32'(row_valid), 32'(1'b0));
  endtask

  function automatic logic [9:0] exp33(input int idx);
    if (idx <= 2) return 10'h3FF;
    if (idx == 5 || idx == 6) return FIG;
    return 10'h000;
  endfunction

  int exp_idx, xfers, seen;

  initial begin
    for (int i = 0; i < 20; i++)
      tbl[i] = '{rdy: 1'b1, vld: 1'b1, idx: 8'(19 - i), dat: exp33(19 - i), last: (i == 19)};
    tbl[20] = '{rdy: 1'b1, vld: 1'b0, idx: 8'd0, dat: 10'h000, last: 1'b0};

    rst = 1'b1; write_mem = 1'b0; row_ready = 1'b0;
    new_border = '0; new_rho_x = '0; new_rho_y = '0;
    #12;
    chk("rst.valid", 32'(row_valid), 32'(0));
    chk("rst.data", 32'(row_data), 32'(0));
    chk("rst.idx", 32'(row_idx), 32'(0));
    chk("rst.last", 32'(frame_last), 32'(0));
    chk("rst.busy", 32'(busy), 32'(0));
    rst = 1'b0;
    step();

    // IDLE ignores row_ready.
    row_ready = 1'b1;
    repeat (3) step();
    chk("idle.valid", 32'(row_valid), 32'(0));

    // Full frame, table driven: borders 3, 2x2 figure at x 4..5, y 5..6.
    load({10{8'd3}}, {8'd5, 8'd4, 8'd5, 8'd4}, {8'd6, 8'd6, 8'd5, 8'd5});
    step();
    write_mem = 1'b0;
    for (int i = 0; i < 21; i++) begin
      row_ready = tbl[i].rdy;
      if (tbl[i].vld) begin
        chk_row("tbl", int'(tbl[i].idx), tbl[i].dat);
        chk("tbl.busy", 32'(busy), 32'(1));
      end else begin
        chk("tbl.valid", 32'(row_valid), 32'(0));
        chk("tbl.last", 32'(frame_last), 32'(0));
        chk("tbl.busy", 32'(busy), 32'(0));
      end
      step();
    end

    // Same frame with row_ready toggling: data held across stalls.
    load({10{8'd3}}, {8'd5, 8'd4, 8'd5, 8'd4}, {8'd6, 8'd6, 8'd5, 8'd5});
    step();
    write_mem = 1'b0;
    exp_idx = 19;
    xfers = 0;
    for (int cyc = 0; cyc < 60 && xfers < 20; cyc++) begin
      row_ready = (cyc % 2 == 0);
      chk_row("stall", exp_idx, exp33(exp_idx));
      if (row_ready && row_valid) begin
        xfers++;
        exp_idx--;
      end
      step();
    end
    chk("stall.xfers", 32'(xfers), 32'(20));
    chk("stall.end_valid", 32'(row_valid), 32'(0));

    // Frame A, B written at row 15, C at row 10: C follows A directly, B dropped.
    load({10{8'd1}}, '0, '0);
    step();
    write_mem = 1'b0;
    row_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      chk_row("A", 19 - cyc, (cyc == 19) ? 10'h3FF : 10'h000);
      if (cyc == 4) load({10{8'd10}}, '0, '0);
      if (cyc == 9) load({72'h0, 8'd20}, '0, '0);
      if (cyc == 6) chk("A.busy_pend", 32'(busy), 32'(1));
      step();
      write_mem = 1'b0;
    end
    drain("C", 19, 20, 10'h001, 10'h000);
    chk("C.busy", 32'(busy), 32'(0));

    // D written on the final transfer of A starts immediately.
    load({10{8'd1}}, '0, '0);
    step();
    write_mem = 1'b0;
    for (int i = 19; i >= 1; i--) step();
    chk_row("A2", 0, 10'h3FF);
    load({8'd20, 72'h0}, '0, '0);
    step();
    write_mem = 1'b0;
    drain("D", 19, 20, 10'h200, 10'h000);

    // Reset at row 12 with a pending snapshot; write_mem during reset is dropped.
    load({10{8'd1}}, '0, '0);
    step();
    write_mem = 1'b0;
    repeat (6) step();
    load({10{8'd10}}, '0, '0);
    step();
    write_mem = 1'b0;
    chk_row("pre_rst", 12, 10'h000);
    rst = 1'b1;
    load({10{8'd10}}, '0, '0);
    #2;
    chk("rst_mid.valid", 32'(row_valid), 32'(0));
    chk("rst_mid.busy", 32'(busy), 32'(0));
    chk("rst_mid.last", 32'(frame_last), 32'(0));
    step();
    rst = 1'b0;
    write_mem = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (row_valid || busy) seen++;
      step();
    end
    chk("post_rst.quiet", 32'(seen), 32'(0));
    load({72'h0, 8'd20}, '0, '0);
    step();
    write_mem = 1'b0;
    drain("R", 19, 20, 10'h001, 10'h000);

    // Tall column 0 and a figure entirely outside the playfield.
    load({72'h0, 8'd255}, {4{8'd12}}, {8'd3, 8'd2, 8'd1, 8'd0});
    step();
    write_mem = 1'b0;
    drain("OOR", 19, 20, 10'h001, 10'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
